// File: rtl/positadd_rr_scheduler.sv
// Round-robin front end that shares one fully pipelined posit adder among NREQ requesters,
// tagging every issued operation so its sum is steered back to the requester that issued it.
module positadd_rr_scheduler #(
    parameter int N       = 32,
    parameter int NREQ    = 4,
    parameter int LATENCY = 4,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_in1,
    input  logic [NREQ*N-1:0] req_in2,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-1:0]      rsp_result,
    output logic              rsp_inf,
    output logic              rsp_zero,
    output logic              add_start,
    output logic [N-1:0]      add_in1,
    output logic [N-1:0]      add_in2,
    input  logic [N-1:0]      add_result,
    input  logic              add_inf,
    input  logic              add_zero,
    input  logic              add_done,
    output logic              err_sync
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int LW = $clog2(LATENCY + 1);

    logic [IW-1:0] ptr;
    logic [CW-1:0] out_cnt [NREQ];
    logic          tag_v   [LATENCY];
    logic [IW-1:0] tag_id  [LATENCY];
    logic [LW-1:0] ign_cnt;
    logic [N-1:0]  hold_in1;
    logic [N-1:0]  hold_in2;

    logic [NREQ-1:0] rsp_hit;
    logic [NREQ-1:0] eligible;
    logic            rsp_any;
    logic            grant;
    logic [IW-1:0]   grant_id;
    logic [IW:0]     cand;
    logic [N-1:0]    sel_in1;
    logic [N-1:0]    sel_in2;

    always_comb begin
        rsp_hit = '0;
        if (reset_n && tag_v[LATENCY-1]) begin
            rsp_hit[tag_id[LATENCY-1]] = 1'b1;
        end
        rsp_any = |rsp_hit;
    end

    // A response leaving this cycle frees its credit immediately, so a lone requester keeps MAX_OUT in flight.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = reset_n && req_valid[i] &&
                          ((out_cnt[i] - CW'(rsp_hit[i])) < CW'(MAX_OUT));
        end
    end

    always_comb begin
        grant    = 1'b0;
        grant_id = '0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!grant && eligible[cand[IW-1:0]]) begin
                grant    = 1'b1;
                grant_id = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[grant_id] = 1'b1;
        end
        sel_in1   = req_in1[int'(grant_id)*N +: N];
        sel_in2   = req_in2[int'(grant_id)*N +: N];
        add_start = grant;
        add_in1   = grant ? sel_in1 : hold_in1;
        add_in2   = grant ? sel_in2 : hold_in2;
    end

    always_comb begin
        rsp_valid  = rsp_hit;
        rsp_result = rsp_any ? add_result : '0;
        rsp_inf    = rsp_any & add_inf;
        rsp_zero   = rsp_any & add_zero;
    end

    // After reset the adder may still emit done pulses for dropped ops, so the check is muted for LATENCY cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr      <= '0;
            hold_in1 <= '0;
            hold_in2 <= '0;
            err_sync <= 1'b0;
            ign_cnt  <= LW'(LATENCY);
            for (int s = 0; s < LATENCY; s++) begin
                tag_v[s]  <= 1'b0;
                tag_id[s] <= '0;
            end
            for (int i = 0; i < NREQ; i++) begin
                out_cnt[i] <= '0;
            end
        end else begin
            if (grant) begin
                ptr      <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
                hold_in1 <= sel_in1;
                hold_in2 <= sel_in2;
            end
            tag_v[0]  <= grant;
            tag_id[0] <= grant_id;
            for (int s = 1; s < LATENCY; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
            for (int i = 0; i < NREQ; i++) begin
                out_cnt[i] <= out_cnt[i] + CW'(req_ready[i]) - CW'(rsp_hit[i]);
            end
            if (ign_cnt != '0) begin
                ign_cnt <= ign_cnt - LW'(1);
            end else if (add_done != tag_v[LATENCY-1]) begin
                err_sync <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_positadd_rr_scheduler.sv
// Directed bench for positadd_rr_scheduler; a small pipelined stand-in plays the posit adder.
module tb_positadd_rr_scheduler;

    localparam int N       = 32;
    localparam int NREQ    = 4;
    localparam int LAT     = 4;
    localparam int MAX_OUT = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_in1;
    logic [NREQ*N-1:0] req_in2;
    logic [NREQ-1:0]   rsp_valid;
    logic [N-1:0]      rsp_result;
    logic              rsp_inf;
    logic              rsp_zero;
    logic              add_start;
    logic [N-1:0]      add_in1;
    logic [N-1:0]      add_in2;
    logic [N-1:0]      add_result;
    logic              add_inf;
    logic              add_zero;
    logic              add_done;
    logic              err_sync;

    int tests_run    = 0;
    int tests_failed = 0;
    bit inject_done  = 1'b0;

    bit          m_v [LAT];
    logic [33:0] m_r [LAT];

    positadd_rr_scheduler #(.N(N), .NREQ(NREQ), .LATENCY(LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_inf(rsp_inf), .rsp_zero(rsp_zero),
        .add_start(add_start), .add_in1(add_in1), .add_in2(add_in2),
        .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done),
        .err_sync(err_sync)
    );

    always #5 clk = ~clk;

    // Adder stand-in: hand-computed posit(32,2) sums for the directed pairs, a marker pattern otherwise.
    function automatic logic [33:0] model_add(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h66531748 && b == 32'h561B6C86) return {2'b00, 32'h6734CE10};
        if (a == 32'hFDEF5956 && b == 32'hB1F685E1) return {2'b00, 32'hB1F68599};
        if (a == 32'h80000000 || b == 32'h80000000) return {2'b10, 32'h80000000};
        if (a == 32'h40000000 && b == 32'hC0000000) return {2'b01, 32'h00000000};
        return {2'b00, a ^ b};
    endfunction

    always @(posedge clk) begin
        m_v[0] <= add_start;
        m_r[0] <= model_add(add_in1, add_in2);
        for (int s = 1; s < LAT; s++) begin
            m_v[s] <= m_v[s-1];
            m_r[s] <= m_r[s-1];
        end
    end

    assign add_done = m_v[LAT-1] | inject_done;
    assign {add_inf, add_zero, add_result} = m_r[LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        req_in1[i*N +: N] = a;
        req_in2[i*N +: N] = b;
    endtask

    task automatic do_reset();
        tick();
        reset_n   = 1'b0;
        req_valid = '0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = '1;
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            tests_run++;
            if (req_ready !== 4'b0000) begin
                tests_failed++;
                $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready);
            end
            tests_run++;
            if (add_start !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_add_start: got %b expected 0", add_start);
            end
            tests_run++;
            if (rsp_valid !== 4'b0000) begin
                tests_failed++;
                $display("[TB] FAIL reset_rsp_valid: got %b expected 0000", rsp_valid);
            end
            tests_run++;
            if (err_sync !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_err_sync: got %b expected 0", err_sync);
            end
        end
        tick();
        reset_n   = 1'b1;
        req_valid = '0;
    endtask

    task automatic test_single_op();
        tick();
        set_req(2, 32'h66531748, 32'h561B6C86);
        req_valid = 4'b0100;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0100 || add_start !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_grant: got ready=%b start=%b expected 0100/1", req_ready, add_start);
        end
        tests_run++;
        if (add_in1 !== 32'h66531748 || add_in2 !== 32'h561B6C86) begin
            tests_failed++;
            $display("[TB] FAIL single_operands: got %h/%h expected 66531748/561b6c86", add_in1, add_in2);
        end
        for (int c = 1; c <= LAT; c++) begin
            tick();
            req_valid = '0;
            @(negedge clk);
            if (c < LAT) begin
                tests_run++;
                if (rsp_valid !== 4'b0000) begin
                    tests_failed++;
                    $display("[TB] FAIL single_early_rsp: cycle %0d got %b expected 0000", c, rsp_valid);
                end
            end else begin
                tests_run++;
                if (rsp_valid !== 4'b0100 || rsp_result !== 32'h6734CE10 || rsp_inf !== 1'b0 || rsp_zero !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL single_rsp: got %b %h inf=%b zero=%b expected 0100 6734ce10 0 0",
                             rsp_valid, rsp_result, rsp_inf, rsp_zero);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_rsp;
        logic [N-1:0]    exp_res;
        int              id;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 32'h11111111 * (i + 1), 32'hA0 + i);
        end
        for (int c = 0; c < 16; c++) begin
            tick();
            req_valid = (c < 12) ? 4'hF : 4'h0;
            @(negedge clk);
            exp_rdy = '0;
            if (c < 12) exp_rdy[c % NREQ] = 1'b1;
            exp_rsp = '0;
            exp_res = '0;
            if (c >= LAT && c - LAT < 12) begin
                id = (c - LAT) % NREQ;
                exp_rsp[id] = 1'b1;
                exp_res = (32'h11111111 * (id + 1)) ^ (32'hA0 + id);
            end
            tests_run++;
            if (req_ready !== exp_rdy) begin
                tests_failed++;
                $display("[TB] FAIL contention_grant: cycle %0d got %b expected %b", c, req_ready, exp_rdy);
            end
            tests_run++;
            if (rsp_valid !== exp_rsp || (exp_rsp != 0 && rsp_result !== exp_res)) begin
                tests_failed++;
                $display("[TB] FAIL contention_rsp: cycle %0d got %b %h expected %b %h",
                         c, rsp_valid, rsp_result, exp_rsp, exp_res);
            end
        end
    endtask

    task automatic test_credit_limit();
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_rsp;
        for (int c = 0; c < 14; c++) begin
            tick();
            req_valid = (c < 12) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            exp_rdy = (c < 12 && (c % 4) < 2) ? 4'b0001 : 4'b0000;
            exp_rsp = (c >= LAT && c - LAT < 12 && ((c - LAT) % 4) < 2) ? 4'b0001 : 4'b0000;
            tests_run++;
            if (req_ready !== exp_rdy) begin
                tests_failed++;
                $display("[TB] FAIL credit_grant: cycle %0d got %b expected %b", c, req_ready, exp_rdy);
            end
            tests_run++;
            if (rsp_valid !== exp_rsp) begin
                tests_failed++;
                $display("[TB] FAIL credit_rsp: cycle %0d got %b expected %b", c, rsp_valid, exp_rsp);
            end
        end
    endtask

    task automatic test_mixed();
        logic [NREQ-1:0] vld_tab [7];
        logic [NREQ-1:0] rdy_tab [7];
        logic [NREQ-1:0] rsp_tab [7];
        logic [33:0]     res_tab [7];
        vld_tab = '{4'b1011, 4'b1001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        rdy_tab = '{4'b0010, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        rsp_tab = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b1000, 4'b0001};
        res_tab = '{34'h0, 34'h0, 34'h0, 34'h0,
                    {2'b00, 32'hB1F68599}, {2'b10, 32'h80000000}, {2'b01, 32'h00000000}};
        set_req(0, 32'h40000000, 32'hC0000000);
        set_req(1, 32'hFDEF5956, 32'hB1F685E1);
        set_req(3, 32'h80000000, 32'h40000000);
        for (int c = 0; c < 7; c++) begin
            tick();
            req_valid = vld_tab[c];
            @(negedge clk);
            tests_run++;
            if (req_ready !== rdy_tab[c]) begin
                tests_failed++;
                $display("[TB] FAIL mixed_grant: cycle %0d got %b expected %b", c, req_ready, rdy_tab[c]);
            end
            tests_run++;
            if (rsp_valid !== rsp_tab[c] ||
                (rsp_tab[c] != 0 && {rsp_inf, rsp_zero, rsp_result} !== res_tab[c])) begin
                tests_failed++;
                $display("[TB] FAIL mixed_rsp: cycle %0d got %b inf=%b zero=%b %h expected %b %h",
                         c, rsp_valid, rsp_inf, rsp_zero, rsp_result, rsp_tab[c], res_tab[c]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [NREQ-1:0] rdy_tab [3];
        logic [NREQ-1:0] tail_rdy [3];
        rdy_tab  = '{4'b0010, 4'b0100, 4'b1000};
        tail_rdy = '{4'b0010, 4'b0010, 4'b0000};
        for (int c = 0; c < 3; c++) begin
            tick();
            req_valid = 4'hF;
            @(negedge clk);
            tests_run++;
            if (req_ready !== rdy_tab[c]) begin
                tests_failed++;
                $display("[TB] FAIL midflight_grant: cycle %0d got %b expected %b", c, req_ready, rdy_tab[c]);
            end
        end
        tick();
        reset_n   = 1'b0;
        req_valid = '0;
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests_run++;
            if (rsp_valid !== 4'b0000 || err_sync !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL midflight_drop: cycle %0d got rsp=%b err=%b expected 0000/0", c, rsp_valid, err_sync);
            end
            tick();
        end
        req_valid = 4'hF;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL midflight_ptr: got %b expected 0001", req_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            req_valid = 4'b0010;
            @(negedge clk);
            tests_run++;
            if (req_ready !== tail_rdy[c]) begin
                tests_failed++;
                $display("[TB] FAIL midflight_credit: cycle %0d got %b expected %b", c, req_ready, tail_rdy[c]);
            end
        end
        tick();
        req_valid = '0;
        repeat (LAT + 2) tick();
    endtask

    task automatic test_err_sync();
        @(negedge clk);
        tests_run++;
        if (err_sync !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL err_clean: got %b expected 0", err_sync);
        end
        tick();
        inject_done = 1'b1;
        tick();
        inject_done = 1'b0;
        @(negedge clk);
        tests_run++;
        if (err_sync !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL err_set: got %b expected 1", err_sync);
        end
        repeat (2) tick();
        @(negedge clk);
        tests_run++;
        if (err_sync !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL err_sticky: got %b expected 1", err_sync);
        end
        do_reset();
        @(negedge clk);
        tests_run++;
        if (err_sync !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL err_cleared: got %b expected 0", err_sync);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_in1   = '0;
        req_in2   = '0;
        test_reset();
        test_single_op();
        test_contention();
        test_credit_limit();
        test_mixed();
        test_reset_midflight();
        test_err_sync();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
